byte_reg_arbiter: RTL and testbench
===================================

// Module: byte_reg_arbiter
// PURPOSE
//  Round-robin write arbiter for one shared 8-bit register.
//  NREQ requesters each present a byte with a valid/ready handshake; one write
//  is granted at a time and committed into the register.
//  Storage is a REG_BYTE2 instance with DIN = wr_fire ? selected byte : DOUT.
//  REG_Q feeds downstream consumers; UPD flags each commit.
// PARAMETERS
//  NREQ  4  number of requesters, 2..8
//  IDW   2  grant-index width, clog2(NREQ); must be >= 1
// PORTS
//  RST        in   1        async reset, active-high
//  CLK        in   1        clock, rising edge
//  REQ_VALID  in   NREQ     per-requester write request
//  REQ_DATA   in   NREQ*8   byte i at [8*i+7:8*i]
//  REQ_READY  out  NREQ     one-hot handshake accept, registered
//  GNT_ID     out  IDW      index of last/current grantee
//  REG_Q      out  8        shared register contents
//  UPD        out  1        1-cycle pulse, cycle after a commit
//  WR_COUNT   out  16       commits since reset, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (async, RST=1): REG_Q=0x00, REQ_READY=0, GNT_ID=0, UPD=0,
//   WR_COUNT=0, rr pointer=0, state=IDLE. Any in-flight write is discarded.
//  FSM states IDLE, WRITE.
//  IDLE:
//   - If any REQ_VALID, select the first set bit searching from ptr upward,
//     with wrap modulo NREQ.
//   - Latch GNT_ID=sel, drive REQ_READY[sel]=1 next cycle, go WRITE.
//   - If no REQ_VALID, stay in IDLE with all outputs held.
//  WRITE:
//   - REQ_READY one-hot at GNT_ID.
//   - If REQ_VALID[GNT_ID]=1: this is the handshake.
//     - REG_Q <= REQ_DATA[GNT_ID] at the closing edge.
//     - WR_COUNT++ and UPD=1 in the following cycle.
//     - ptr <= GNT_ID+1 (mod NREQ).
//   - If REQ_VALID[GNT_ID]=0 (protocol violation): no write, no UPD, ptr
//     unchanged.
//   - Always return to IDLE; REQ_READY drops to 0.
//  Latency: VALID seen in cycle n -> READY in n+1 -> REG_Q new in n+2.
//   Max rate is 1 commit per 2 cycles.
//  Requesters hold VALID and DATA stable until READY. Data is sampled only in
//   the READY cycle.
//  Valids rising while in WRITE are arbitrated in the next IDLE cycle;
//   nothing is lost.
//  Simultaneous requests: the lowest index at or above ptr wins.
//   All NREQ valid continuously -> grants rotate 0,1,..,NREQ-1,0.
//  GNT_ID holds after a commit until the next grant.
//  Never more than one REQ_READY bit high at a time.
// CONFIGURATION
//  BYTE_ARB_LOCK_EN defined:
//   - Adds port REQ_LOCK in NREQ.
//   - A commit with REQ_LOCK[GNT_ID]=1 sets owner=GNT_ID. While owned, IDLE
//     considers only REQ_VALID[owner]; others wait.
//   - A commit by the owner with REQ_LOCK=0 releases ownership.
//   - ptr advances only on the releasing commit.
//   - Reset clears ownership.
//  BYTE_ARB_LOCK_EN undefined: no REQ_LOCK port; pure round-robin as above.
// TESTING
//  1. Reset mid-WRITE (RST during READY=1) -> REG_Q=0x00, READY=0,
//     WR_COUNT=0 immediately; no commit after release.
//  2. Single req: VALID[2]=1, DATA=0xA5 at cycle n -> READY[2]=1 at n+1;
//     REG_Q=0xA5, UPD=1, WR_COUNT=1 at n+2.
//  3. All 4 valid continuously, DATA=0x10+i -> GNT_ID 0,1,2,3,0; REG_Q
//     0x10,0x11,0x12,0x13 every 2 cycles.
//  4. VALID[1] dropped during its READY cycle -> REG_Q unchanged, no UPD;
//     next grant still starts search at old ptr.
//  5. WR_COUNT preloaded by 65535 commits -> next commit gives 0x0000.
//  6. (LOCK_EN) req0 commits with LOCK=1 while req1 valid -> req1 starved
//     until req0 commits with LOCK=0; then GNT_ID=1.

Source files
------------

// File: rtl/byte_reg_arbiter.sv
// Round-robin write arbiter for one shared 8-bit register (REG_BYTE2 storage).
// Optional owner locking is enabled with the BYTE_ARB_LOCK_EN macro.

module REG_BYTE2 (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] DIN,
  output logic [7:0] DOUT
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) DOUT <= 8'h00;
    else     DOUT <= DIN;
  end

endmodule

module byte_reg_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              RST,
  input  logic              CLK,
  input  logic [NREQ-1:0]   REQ_VALID,
  input  logic [NREQ*8-1:0] REQ_DATA,
  output logic [NREQ-1:0]   REQ_READY,
  output logic [IDW-1:0]    GNT_ID,
  output logic [7:0]        REG_Q,
  output logic              UPD,
  output logic [15:0]       WR_COUNT
`ifdef BYTE_ARB_LOCK_EN
  ,
  input  logic [NREQ-1:0]   REQ_LOCK
`endif
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] cand;
  logic [IDW-1:0]  sel;
  logic            found;
  logic            wr_fire;
  logic [IDW-1:0]  gnt_next;
  logic [7:0]      reg_din;

`ifdef BYTE_ARB_LOCK_EN
  logic            owned;
  logic [IDW-1:0]  owner;
`endif

  // While a requester owns the register only its valid is arbitrated.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    cand = REQ_VALID;
`ifdef BYTE_ARB_LOCK_EN
    if (owned) begin
      cand = '0;
      cand[owner] = REQ_VALID[owner];
    end
`endif
  end

  // First set candidate searching upward from ptr, wrapping modulo NREQ.
  always_comb begin
    sel   = ptr;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      int k;
      k = int'(ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      if (!found && cand[k]) begin
        sel   = IDW'(k);
        found = 1'b1;
      end
    end
  end

  assign wr_fire  = (state == S_WRITE) && REQ_VALID[GNT_ID];
  assign gnt_next = (GNT_ID == IDW'(NREQ - 1)) ? '0 : GNT_ID + 1'b1;
  assign reg_din  = wr_fire ? REQ_DATA[8*GNT_ID +: 8] : REG_Q;

  REG_BYTE2 u_reg (
    .CLK  (CLK),
    .RST  (RST),
    .DIN  (reg_din),
    .DOUT (REG_Q)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      ptr       <= '0;
      REQ_READY <= '0;
      GNT_ID    <= '0;
      UPD       <= 1'b0;
      WR_COUNT  <= 16'h0000;
`ifdef BYTE_ARB_LOCK_EN
      owned     <= 1'b0;
      owner     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          UPD <= 1'b0;
          if (found) begin
            GNT_ID         <= sel;
            REQ_READY      <= '0;
            REQ_READY[sel] <= 1'b1;
            state          <= S_WRITE;
          end
        end
        S_WRITE: begin
          REQ_READY <= '0;
          UPD       <= wr_fire;
          state     <= S_IDLE;
          if (wr_fire) begin
            WR_COUNT <= WR_COUNT + 16'd1;
`ifdef BYTE_ARB_LOCK_EN
            // A locking commit keeps the pointer; the releasing commit advances it.
            if (REQ_LOCK[GNT_ID]) begin
              owned <= 1'b1;
              owner <= GNT_ID;
            end else begin
              owned <= 1'b0;
              ptr   <= gnt_next;
            end
`else
            ptr <= gnt_next;
`endif
          end
        end
        default: begin
          state     <= S_IDLE;
          REQ_READY <= '0;
          UPD       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_reg_arbiter.sv
// Directed self-checking bench for byte_reg_arbiter (NREQ=4); lock scenario
// runs only when BYTE_ARB_LOCK_EN is defined.

module tb_byte_reg_arbiter;

  logic        RST;
  logic        CLK;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [1:0]  gnt_id;
  logic [7:0]  reg_q;
  logic        upd;
  logic [15:0] wr_count;
`ifdef BYTE_ARB_LOCK_EN
  logic [3:0]  req_lock;
`endif

  int errors = 0;
  int checks = 0;

  byte_reg_arbiter #(.NREQ(4), .IDW(2)) dut (
    .RST       (RST),
    .CLK       (CLK),
    .REQ_VALID (req_valid),
    .REQ_DATA  (req_data),
    .REQ_READY (req_ready),
    .GNT_ID    (gnt_id),
    .REG_Q     (reg_q),
    .UPD       (upd),
    .WR_COUNT  (wr_count)
`ifdef BYTE_ARB_LOCK_EN
    ,
    .REQ_LOCK  (req_lock)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    RST       = 1'b1;
    req_valid = 4'b0000;
    req_data  = 32'h0;
`ifdef BYTE_ARB_LOCK_EN
    req_lock  = 4'b0000;
`endif
    @(negedge CLK);
    @(negedge CLK);
    check("rst_reg_q", 32'(reg_q), 32'h00);
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_gnt", 32'(gnt_id), 32'd0);
    check("rst_upd", 32'(upd), 32'd0);
    check("rst_count", 32'(wr_count), 32'd0);
    RST = 1'b0;
    tick();
    check("idle_ready", 32'(req_ready), 32'h0);

    // All four valid: grants rotate 0,1,2,3,0 one commit per two cycles.
    req_valid = 4'b1111;
    req_data  = 32'h13121110;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("rr_gnt%0d", k), 32'(gnt_id), 32'(k % 4));
      check($sformatf("rr_ready%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
      tick();
      check($sformatf("rr_q%0d", k), 32'(reg_q), 32'(8'h10 + (k % 4)));
      check($sformatf("rr_upd%0d", k), 32'(upd), 32'd1);
      check($sformatf("rr_ready_off%0d", k), 32'(req_ready), 32'h0);
    end
    req_valid = 4'b0000;
    check("rr_count", 32'(wr_count), 32'd5);

    // Single request on index 2 (ptr is 1 after the last grant of 0).
    req_valid = 4'b0100;
    req_data  = 32'h00A50000;
    tick();
    check("single_ready", 32'(req_ready), 32'b0100);
    check("single_gnt", 32'(gnt_id), 32'd2);
    check("single_q_before", 32'(reg_q), 32'h10);
    check("single_upd_before", 32'(upd), 32'd0);
    tick();
    req_valid = 4'b0000;
    check("single_q", 32'(reg_q), 32'hA5);
    check("single_upd", 32'(upd), 32'd1);
    check("single_count", 32'(wr_count), 32'd6);
    tick();
    check("upd_pulse_end", 32'(upd), 32'd0);
    check("gnt_hold", 32'(gnt_id), 32'd2);

    // Valid[1] withdrawn during its READY cycle; ptr must stay at 3.
    req_valid = 4'b0010;
    req_data  = 32'h0000EE3C;
    tick();
    check("drop_ready", 32'(req_ready), 32'b0010);
    check("drop_gnt", 32'(gnt_id), 32'd1);
    req_valid = 4'b0000;
    tick();
    check("drop_q", 32'(reg_q), 32'hA5);
    check("drop_upd", 32'(upd), 32'd0);
    check("drop_count", 32'(wr_count), 32'd6);
    check("drop_ready_off", 32'(req_ready), 32'h0);
    req_valid = 4'b0101;
    tick();
    check("oldptr_gnt", 32'(gnt_id), 32'd0);
    check("oldptr_ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0000;
    check("oldptr_q", 32'(reg_q), 32'h3C);
    check("oldptr_count", 32'(wr_count), 32'd7);

    // Counter wrap: preload 0xFFFF, then one commit from requester 1.
    force dut.WR_COUNT = 16'hFFFF;
    #1;
    release dut.WR_COUNT;
    #1;
    check("preload_count", 32'(wr_count), 32'hFFFF);
    req_valid = 4'b0010;
    req_data  = 32'h00005A00;
    tick();
    check("wrap_gnt", 32'(gnt_id), 32'd1);
    tick();
    req_valid = 4'b0000;
    check("wrap_count", 32'(wr_count), 32'h0000);
    check("wrap_q", 32'(reg_q), 32'h5A);
    check("wrap_upd", 32'(upd), 32'd1);

    // Reset asserted while READY is high discards the write.
    req_valid = 4'b0100;
    req_data  = 32'h00770000;
    tick();
    check("mid_ready", 32'(req_ready), 32'b0100);
    #2;
    RST = 1'b1;
    #1;
    check("mid_rst_q", 32'(reg_q), 32'h00);
    check("mid_rst_ready", 32'(req_ready), 32'h0);
    check("mid_rst_count", 32'(wr_count), 32'd0);
    check("mid_rst_gnt", 32'(gnt_id), 32'd0);
    @(negedge CLK);
    req_valid = 4'b0000;
    RST = 1'b0;
    tick();
    tick();
    check("post_rst_q", 32'(reg_q), 32'h00);
    check("post_rst_count", 32'(wr_count), 32'd0);
    check("post_rst_upd", 32'(upd), 32'd0);

    // Pointer restarts at 0: requests 1 and 3 -> 1 wins.
    req_valid = 4'b1010;
    req_data  = 32'h44003300;
    tick();
    check("ptr_rst_gnt", 32'(gnt_id), 32'd1);
    tick();
    req_valid = 4'b0000;
    check("ptr_rst_q", 32'(reg_q), 32'h33);

`ifdef BYTE_ARB_LOCK_EN
    // Lock scenario after a clean reset: req0 locks, req1 starves until release.
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    req_valid = 4'b0011;
    req_data  = 32'h00000201;
    req_lock  = 4'b0001;
    tick();
    check("lock_gnt0", 32'(gnt_id), 32'd0);
    tick();
    check("lock_q0", 32'(reg_q), 32'h01);
    tick();
    check("lock_starve_gnt", 32'(gnt_id), 32'd0);
    req_lock = 4'b0000;
    tick();
    check("lock_release_count", 32'(wr_count), 32'd2);
    req_valid = 4'b0010;
    tick();
    check("lock_after_gnt", 32'(gnt_id), 32'd1);
    tick();
    req_valid = 4'b0000;
    check("lock_after_q", 32'(reg_q), 32'h02);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
